ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB slave endpoint that sits directly downstream of the AHB_bus interconnect and consumes one slave port (hsel, address/control, hwdata).
- Provides a word-organised SRAM model with programmable wait states, byte/halfword/word writes and OKAY/ERROR responses.
- Used as the default memory target behind slave ports in the CRV bench and as a synthesizable on-chip RAM.

Parameters:
- ADDR_W, 32, width of haddr
- DATA_W, 32, data bus width; only 32 is supported
- MEM_WORDS, 1024, SRAM depth in 32-bit words; power of two
- WAIT_CYCLES, 0, wait states inserted per transfer data phase (0..15)

Ports:
- hclk  input  1  bus clock
- hreset_n  input  1  asynchronous active-low reset
- hsel  input  1  slave select from the interconnect decoder
- haddr  input  ADDR_W  transfer address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1=write
- hsize  input  3  0=byte, 1=half, 2=word; others are illegal
- hburst  input  3  burst type; informational only, not decoded
- hwdata  input  DATA_W  write data, data phase
- hready  input  1  bus-level ready (previous transfer completing)
- hrdata  output  DATA_W  read data
- hreadyout  output  1  slave ready
- hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Clock and reset:
  - Single clock hclk.
  - Reset is asynchronous and active-low on hreset_n.
  - Reset values: hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0, all captured address-phase registers=0. SRAM contents are not reset.
- Reset mid-transfer aborts the transfer; a pending write is not committed.
- Address phase accept:
  - Condition: hsel & hready & htrans[1] at a rising edge.
  - Captures haddr, hwrite, hsize.
  - IDLE or BUSY transfers, or hsel=0, are not accepted; they get a zero-wait OKAY (hreadyout stays 1).
- State machine:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0, else DATA.
  - WAIT: hreadyout=0. Counter loads WAIT_CYCLES-1 and decrements each cycle. At 0, go to DATA.
  - DATA: hreadyout=1, hresp=0; the transfer completes this cycle.
    - A new accept in the same cycle (pipelined back-to-back) restarts WAIT/DATA.
    - Otherwise return to IDLE.
  - ERR1: hreadyout=0, hresp=1. Next state is ERR2.
  - ERR2: hreadyout=1, hresp=1. ERR2 ignores any accept and returns to IDLE; the master cancels the following transfer per AHB.
- Total latency: accept to completion = WAIT_CYCLES+1 cycles.
- Writes:
  - Committed at the rising edge that ends the DATA cycle, using hwdata sampled at that edge.
  - Byte lanes:
    - byte: lane haddr[1:0]
    - half: lanes {haddr[1],0} and {haddr[1],1}
    - word: all 4 lanes
- Reads: hrdata = mem[captured addr word index] during WAIT and DATA. It is held at its last value otherwise.
- Read-after-write: a read data phase immediately following a write to the same word returns the new data, merged per byte lane. A bypass is required.
- Index: word index = haddr[log2(MEM_WORDS)+1:2].
- Without the feature: addresses beyond MEM_WORDS wrap modulo depth; hsize>2 is treated as word.

Optional Feature:
- AHB_SLV_ERR_EN defined: each accepted transfer enters ERR1 instead of WAIT/DATA, and no memory write occurs, when any of these holds:
  - haddr is at or above MEM_WORDS*4 (within the slave's region)
  - it is misaligned (half with haddr[0]=1; word with haddr[1:0]≠0)
  - hsize>2
- Undefined: no ERR1/ERR2 states exist, hresp is tied to 0, and the address wraps modulo depth.

Test Plan:
- Reset: assert hreset_n=0 mid-WAIT (WAIT_CYCLES=3) -> outputs go immediately to hreadyout=1, hresp=0, hrdata=0; the aborted write is not visible on a later read.
- Zero-wait word write then read: write 0xDEADBEEF to 0x10, read 0x10 back-to-back -> read completes 1 cycle after accept with hrdata=0xDEADBEEF, hresp=0.
- Byte write: word 0x20 preset to 0x11223344, byte write 0xAA at 0x21 -> read returns 0x1122AA44.
- WAIT_CYCLES=2 back-to-back SEQ burst of 4 reads -> hreadyout low exactly 2 cycles per beat; 12 cycles total.
- IDLE/BUSY with hsel=1 -> hreadyout stays 1, hresp=0, memory unchanged.
- AHB_SLV_ERR_EN, word read at 0x1002 -> hreadyout=0/hresp=1 then hreadyout=1/hresp=1, then IDLE; a write at 0x1000 (MEM_WORDS=1024, out of range) yields ERROR with no write.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-port bundle between the interconnect (master side) and an SRAM slave.
// Latency: none, wiring only.
// Backpressure: hreadyout from the slave stretches the data phase; hready is the bus-level ready.
// Signals: hsel/haddr/htrans/hwrite/hsize/hburst/hwdata/hready towards the slave,
//          hrdata/hreadyout/hresp back to the master.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic [DATA_W-1:0] hrdata;
  logic              hreadyout;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB slave in front of a word-organised SRAM with byte/half/word writes.
// Latency: accept to completion = WAIT_CYCLES+1 cycles (ERROR responses take two cycles).
// Backpressure: hreadyout is held low for WAIT_CYCLES cycles of every data phase.
// Ports: hclk, hreset_n (async active-low), bus (ahb_sram_slave_if.slave).
// Optional macro AHB_SLV_ERR_EN: out-of-range, misaligned or hsize>2 transfers get a
// two-cycle ERROR response and never write; without it addresses wrap and hsize>2 acts as word.
module ahb_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic          hclk,
  input logic          hreset_n,
  ahb_sram_slave_if.slave bus
);
  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef AHB_SLV_ERR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_e;
`endif

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic                hreadyout_q, hreadyout_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  logic                accept;
  logic                start;
  logic                commit;
  logic [3:0]          be;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_bits;

  assign accept = bus.hsel & bus.hready & bus.htrans[1];

`ifdef AHB_SLV_ERR_EN
  logic hresp_q, hresp_d;
  logic req_err;
  assign req_err = (|bus.haddr[ADDR_W-1:IDX_W+2])
                 | ((bus.hsize == 3'd1) & bus.haddr[0])
                 | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00))
                 | (bus.hsize > 3'd2);
`endif

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: start = accept;
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      // A pipelined accept during the completing cycle starts the next transfer directly.
      ST_DATA: begin
        state_d = ST_IDLE;
        start   = accept;
      end
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
      // Any accept seen here belongs to a transfer the master must cancel.
      ST_ERR2: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      addr_d  = bus.haddr;
      write_d = bus.hwrite;
      size_d  = bus.hsize;
`ifdef AHB_SLV_ERR_EN
      if (req_err) begin
        state_d = ST_ERR1;
      end else
`endif
      if (WAIT_CYCLES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_LOAD;
      end else begin
        state_d = ST_DATA;
      end
    end

    hreadyout_d = (state_d != ST_WAIT);
`ifdef AHB_SLV_ERR_EN
    if (state_d == ST_ERR1) hreadyout_d = 1'b0;
    hresp_d = (state_d == ST_ERR1) || (state_d == ST_ERR2);
`endif
  end

  // Write path: the DATA cycle's edge commits hwdata through the byte-lane mask.
  assign commit = (state_q == ST_DATA) & write_q;
  assign wr_idx = addr_q[IDX_W+1:2];
  assign rd_idx = addr_d[IDX_W+1:2];

  always_comb begin
    unique case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    wr_word = mem[wr_idx];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wr_word[8*b +: 8] = bus.hwdata[8*b +: 8];
    end
  end

  // Read path: the array still holds the old word at the committing edge, so a read
  // starting on that same edge to the same word takes the merged write data instead.
  always_comb begin
    rd_word  = (commit && (rd_idx == wr_idx)) ? wr_word : mem[rd_idx];
    hrdata_d = ((state_d == ST_WAIT) || (state_d == ST_DATA)) ? rd_word : hrdata_q;
  end

  always_ff @(posedge hclk) begin
    if (commit) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
`ifdef AHB_SLV_ERR_EN
      hresp_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hrdata_q    <= hrdata_d;
`ifdef AHB_SLV_ERR_EN
      hresp_q     <= hresp_d;
`endif
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hrdata    = hrdata_q;
`ifdef AHB_SLV_ERR_EN
  assign bus.hresp     = hresp_q;
`else
  assign bus.hresp     = 1'b0;
`endif

  // Burst type is informational; upper address bits only matter for the range check.
  assign unused_bits = ^{bus.hburst, addr_q[ADDR_W-1:IDX_W+2]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: three instances (0, 2 and 3 wait states)
// share one pipelined AHB master; dsel picks which instance the master talks to.
module tb_ahb_sram_slave;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          dsel;
  logic        hsel_d;
  logic [31:0] haddr_d;
  logic [1:0]  htrans_d;
  logic        hwrite_d;
  logic [2:0]  hsize_d;
  logic [31:0] hwdata_d;

  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  assign bus0.hsel = hsel_d & (dsel == 0);
  assign bus2.hsel = hsel_d & (dsel == 1);
  assign bus3.hsel = hsel_d & (dsel == 2);
  assign bus0.haddr = haddr_d;   assign bus2.haddr = haddr_d;   assign bus3.haddr = haddr_d;
  assign bus0.htrans = htrans_d; assign bus2.htrans = htrans_d; assign bus3.htrans = htrans_d;
  assign bus0.hwrite = hwrite_d; assign bus2.hwrite = hwrite_d; assign bus3.hwrite = hwrite_d;
  assign bus0.hsize = hsize_d;   assign bus2.hsize = hsize_d;   assign bus3.hsize = hsize_d;
  assign bus0.hburst = 3'd1;     assign bus2.hburst = 3'd1;     assign bus3.hburst = 3'd1;
  assign bus0.hwdata = hwdata_d; assign bus2.hwdata = hwdata_d; assign bus3.hwdata = hwdata_d;
  assign bus0.hready = bus0.hreadyout;
  assign bus2.hready = bus2.hreadyout;
  assign bus3.hready = bus3.hreadyout;

  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .WAIT_CYCLES(0))
    u_w0 (.hclk(clk), .hreset_n(rst_n), .bus(bus0.slave));
  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .WAIT_CYCLES(2))
    u_w2 (.hclk(clk), .hreset_n(rst_n), .bus(bus2.slave));
  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .WAIT_CYCLES(3))
    u_w3 (.hclk(clk), .hreset_n(rst_n), .bus(bus3.slave));

  logic        rdy_m, resp_m;
  logic [31:0] rd_m;
  always_comb begin
    rdy_m = bus0.hreadyout; resp_m = bus0.hresp; rd_m = bus0.hrdata;
    if (dsel == 1) begin
      rdy_m = bus2.hreadyout; resp_m = bus2.hresp; rd_m = bus2.hrdata;
    end else if (dsel == 2) begin
      rdy_m = bus3.hreadyout; resp_m = bus3.hresp; rd_m = bus3.hrdata;
    end
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          idx;
    logic        err;
    logic        chk;
    logic [31:0] rd;
    int          waits;
  } sb_t;

  vec_t vt[64];
  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             input logic err, input logic chk, input logic [31:0] exp);
    vec_t r;
    r.sel = sel; r.trans = tr; r.wr = wr; r.size = sz; r.addr = a; r.wdata = wd;
    r.exp_err = err; r.chk_rd = chk; r.exp_rd = exp;
    return r;
  endfunction

  function automatic int wc_of(input int d);
    if (d == 1) return 2;
    if (d == 2) return 3;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pipelined AHB master over vt[first..last]; returns edges from first accept to last completion.
  task automatic run_seq(input int first, input int last, output int cyc);
    int   ai, dp, waits, first_acc, last_cmp, n;
    bit   dp_vld;
    sb_t  e;
    ai = first; dp = 0; dp_vld = 0; waits = 0; first_acc = -1; last_cmp = 0; n = 0;
    while ((ai <= last || dp_vld) && n < 200) begin
      if (ai <= last) begin
        hsel_d = vt[ai].sel; htrans_d = vt[ai].trans; hwrite_d = vt[ai].wr;
        hsize_d = vt[ai].size; haddr_d = vt[ai].addr;
      end else begin
        hsel_d = 1'b0; htrans_d = 2'b00; hwrite_d = 1'b0;
      end
      hwdata_d = dp_vld ? vt[dp].wdata : 32'h0;
      @(negedge clk);
      if (dp_vld) begin
        if (!rdy_m) begin
          waits++;
          chk("wait_hresp", {31'b0, resp_m}, {31'b0, sb[0].err});
        end else begin
          e = sb.pop_front();
          chk($sformatf("beat%0d_waits", e.idx), waits, e.waits);
          chk($sformatf("beat%0d_hresp", e.idx), {31'b0, resp_m}, {31'b0, e.err});
          if (e.chk && !e.err) chk($sformatf("beat%0d_hrdata", e.idx), rd_m, e.rd);
          dp_vld = 0; waits = 0; last_cmp = n;
        end
      end else begin
        chk("idle_ready", {30'b0, rdy_m, resp_m}, 32'd2);
      end
      if (rdy_m && ai <= last) begin
        if (vt[ai].sel && vt[ai].trans[1]) begin
          e.idx = ai; e.err = vt[ai].exp_err; e.chk = vt[ai].chk_rd; e.rd = vt[ai].exp_rd;
          e.waits = vt[ai].exp_err ? 1 : wc_of(dsel);
          sb.push_back(e);
          dp = ai; dp_vld = 1;
          if (first_acc < 0) first_acc = n;
        end
        ai++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL seq_timeout: got %0d cycles expected completion below 200", n);
    end
    cyc = last_cmp - first_acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] a, d;
    // dut0, zero wait states
    vt[0]  = v(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    vt[1]  = v(1, 2'd2, 0, 3'd2, 32'h10, 32'h0,       0, 1, 32'hDEADBEEF);
    vt[2]  = v(1, 2'd2, 1, 3'd2, 32'h20, 32'h11223344, 0, 0, 0);
    vt[3]  = v(1, 2'd2, 1, 3'd0, 32'h21, 32'h5555AA55, 0, 0, 0);
    vt[4]  = v(1, 2'd2, 0, 3'd2, 32'h20, 32'h0,       0, 1, 32'h1122AA44);
    vt[5]  = v(1, 2'd2, 1, 3'd1, 32'h22, 32'hBEEF1234, 0, 0, 0);
    vt[6]  = v(0, 2'd0, 0, 3'd2, 32'h0,  32'h0,       0, 0, 0);
    vt[7]  = v(1, 2'd2, 0, 3'd2, 32'h20, 32'h0,       0, 1, 32'hBEEFAA44);
    vt[8]  = v(1, 2'd0, 1, 3'd2, 32'h10, 32'h0,       0, 0, 0);
    vt[9]  = v(1, 2'd1, 1, 3'd2, 32'h10, 32'h0,       0, 0, 0);
    vt[10] = v(1, 2'd2, 0, 3'd2, 32'h10, 32'h0,       0, 1, 32'hDEADBEEF);
    vt[11] = v(0, 2'd2, 1, 3'd2, 32'h10, 32'h0,       0, 0, 0);
    vt[12] = v(1, 2'd2, 0, 3'd2, 32'h10, 32'h0,       0, 1, 32'hDEADBEEF);
    vt[13] = v(1, 2'd2, 1, 3'd2, 32'h0,  32'h55AA55AA, 0, 0, 0);
`ifdef AHB_SLV_ERR_EN
    vt[14] = v(1, 2'd2, 0, 3'd2, 32'h1002, 32'h0,       1, 0, 0);
    vt[15] = v(0, 2'd0, 0, 3'd2, 32'h0,    32'h0,       0, 0, 0);
    vt[16] = v(1, 2'd2, 1, 3'd2, 32'h1000, 32'h0BADF00D, 1, 0, 0);
    vt[17] = v(0, 2'd0, 0, 3'd2, 32'h0,    32'h0,       0, 0, 0);
    vt[18] = v(1, 2'd2, 0, 3'd2, 32'h0,    32'h0,       0, 1, 32'h55AA55AA);
    vt[19] = v(1, 2'd2, 1, 3'd1, 32'h21,   32'hFFFFFFFF, 1, 0, 0);
    vt[20] = v(0, 2'd0, 0, 3'd2, 32'h0,    32'h0,       0, 0, 0);
    vt[21] = v(1, 2'd2, 0, 3'd2, 32'h20,   32'h0,       0, 1, 32'hBEEFAA44);
`else
    vt[14] = v(1, 2'd2, 1, 3'd2, 32'h1000, 32'h0BADF00D, 0, 0, 0);
    vt[15] = v(1, 2'd2, 0, 3'd2, 32'h0,    32'h0,       0, 1, 32'h0BADF00D);
    vt[16] = v(1, 2'd2, 1, 3'd3, 32'h24,   32'h01020304, 0, 0, 0);
    vt[17] = v(1, 2'd2, 0, 3'd2, 32'h24,   32'h0,       0, 1, 32'h01020304);
    vt[18] = v(0, 2'd0, 0, 3'd2, 32'h0,    32'h0,       0, 0, 0);
    vt[19] = v(1, 2'd2, 0, 3'd2, 32'h1020, 32'h0,       0, 1, 32'hBEEFAA44);
    vt[20] = v(0, 2'd0, 0, 3'd2, 32'h0,    32'h0,       0, 0, 0);
    vt[21] = v(1, 2'd2, 0, 3'd2, 32'h20,   32'h0,       0, 1, 32'hBEEFAA44);
`endif
    // dut2, two wait states: write burst then read burst
    vt[22] = v(1, 2'd2, 1, 3'd2, 32'h100, 32'hA0000001, 0, 0, 0);
    vt[23] = v(1, 2'd3, 1, 3'd2, 32'h104, 32'hA0000002, 0, 0, 0);
    vt[24] = v(1, 2'd3, 1, 3'd2, 32'h108, 32'hA0000003, 0, 0, 0);
    vt[25] = v(1, 2'd3, 1, 3'd2, 32'h10C, 32'hA0000004, 0, 0, 0);
    vt[26] = v(0, 2'd0, 0, 3'd2, 32'h0,   32'h0,        0, 0, 0);
    vt[27] = v(1, 2'd2, 0, 3'd2, 32'h100, 32'h0, 0, 1, 32'hA0000001);
    vt[28] = v(1, 2'd3, 0, 3'd2, 32'h104, 32'h0, 0, 1, 32'hA0000002);
    vt[29] = v(1, 2'd3, 0, 3'd2, 32'h108, 32'h0, 0, 1, 32'hA0000003);
    vt[30] = v(1, 2'd3, 0, 3'd2, 32'h10C, 32'h0, 0, 1, 32'hA0000004);
    vt[31] = v(0, 2'd0, 0, 3'd2, 32'h0,   32'h0, 0, 0, 0);
    // dut3, three wait states: preset, reset mid-write, read back
    vt[32] = v(1, 2'd2, 1, 3'd2, 32'h40, 32'h12345678, 0, 0, 0);
    vt[33] = v(0, 2'd0, 0, 3'd2, 32'h0,  32'h0,        0, 0, 0);
    vt[34] = v(1, 2'd2, 0, 3'd2, 32'h40, 32'h0,        0, 1, 32'h12345678);
    vt[35] = v(0, 2'd0, 0, 3'd2, 32'h0,  32'h0,        0, 0, 0);

    dsel = 0; hsel_d = 0; haddr_d = 0; htrans_d = 0; hwrite_d = 0; hsize_d = 3'd2; hwdata_d = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_w0", {bus0.hreadyout, bus0.hresp, bus0.hrdata[29:0]}, 32'h80000000);
    chk("rst_w2", {bus2.hreadyout, bus2.hresp, bus2.hrdata[29:0]}, 32'h80000000);
    chk("rst_w3", {bus3.hreadyout, bus3.hresp, bus3.hrdata[29:0]}, 32'h80000000);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    dsel = 0; run_seq(0, 21, cyc);
    dsel = 1; run_seq(22, 26, cyc);
    run_seq(27, 31, cyc);
    chk("burst_cycles", cyc, 32'd12);

    dsel = 2; run_seq(32, 33, cyc);
    // write to 0x40 with three wait states, reset lands in the second wait cycle
    hsel_d = 1; htrans_d = 2'd2; hwrite_d = 1; hsize_d = 3'd2; haddr_d = 32'h40; hwdata_d = 0;
    @(posedge clk); #1;
    hsel_d = 0; htrans_d = 2'd0; hwrite_d = 0; hwdata_d = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("midwait_ready", {31'b0, rdy_m}, 32'd0);
    chk("midwait_hrdata", rd_m, 32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {31'b0, rdy_m}, 32'd1);
    chk("rst_mid_hresp", {31'b0, resp_m}, 32'd0);
    chk("rst_mid_hrdata", rd_m, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    hwdata_d = 0;
    run_seq(34, 35, cyc);

    // back-to-back random word write/read pairs on the zero-wait instance
    for (int k = 0; k < 6; k++) begin
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      d = $urandom;
      vt[36 + 2*k] = v(1, 2'd2, 1, 3'd2, a, d,     0, 0, 0);
      vt[37 + 2*k] = v(1, 2'd2, 0, 3'd2, a, 32'h0, 0, 1, d);
    end
    vt[48] = v(0, 2'd0, 0, 3'd2, 32'h0, 32'h0, 0, 0, 0);
    dsel = 0; run_seq(36, 48, cyc);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
